// File: rtl/spi_dev_pkg.sv
// Shared constants for the oversampled SPI device core: mode encodings,
// synchroniser depth and the default underrun fill word.
package spi_dev_pkg;

    // Mode encoding is {CPOL, CPHA}.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int SYNC_DEPTH = 2;

    function automatic logic [31:0] default_fill(input int width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/spi_dev_sync_fifo.sv
// Small synchronous FIFO with show-ahead read data; pushes when full and
// pops when empty are ignored.
module spi_dev_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/spi_dev_sync_core.sv
// SPI device core with SCK/CS_n/MOSI oversampled in the clk domain.
// Define SPI_DEV_SYNC_TX_FIFO_EN for a TX_DEPTH-word TX FIFO instead of a single holding register.
module spi_dev_sync_core
    import spi_dev_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter bit               CPOL     = 1'b0,
    parameter bit               CPHA     = 1'b0,
    parameter logic [WIDTH-1:0] FILL     = WIDTH'(default_fill(WIDTH)),
    parameter int               TX_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_sck,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic             csn_state,
    output logic             csn_fall,
    output logic             csn_rise
);
    localparam int CW = $clog2(WIDTH);

    if (WIDTH < 4 || WIDTH > 32 || TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_param_check
        $error("spi_dev_sync_core: WIDTH must be 4..32 and TX_DEPTH a power of two >= 2");
    end

    logic [SYNC_DEPTH-1:0] sck_sync, csn_sync, mosi_sync;
    logic                  sck_hist, csn_hist;
    logic                  started, armed;
    logic                  sck_s, csn_s, mosi_s;
    logic                  lead_edge, trail_edge, sample_edge, shift_edge;
    logic                  active, word_done, fetch;
    logic [CW-1:0]         bit_cnt;
    logic [WIDTH-2:0]      rx_shift;
    logic [WIDTH-1:0]      rx_next, tx_shift;
    logic                  buf_empty, pop;
    logic [WIDTH-1:0]      buf_data;

    // The engine stays idle until CS_n has been seen high after reset, so a
    // CS_n that is already low at reset release never starts a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= {SYNC_DEPTH{CPOL}};
            csn_sync  <= '1;
            mosi_sync <= '0;
            sck_hist  <= CPOL;
            csn_hist  <= 1'b1;
            started   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_DEPTH-2:0], spi_sck};
            csn_sync  <= {csn_sync[SYNC_DEPTH-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_DEPTH-2:0], spi_mosi};
            sck_hist  <= sck_s;
            csn_hist  <= csn_s;
            started   <= 1'b1;
            if (started && csn_sync[0]) armed <= 1'b1;
        end
    end

    assign sck_s       = sck_sync[SYNC_DEPTH-1];
    assign csn_s       = csn_sync[SYNC_DEPTH-1];
    assign mosi_s      = mosi_sync[SYNC_DEPTH-1];
    assign lead_edge   = (sck_s != sck_hist) && (sck_s != CPOL);
    assign trail_edge  = (sck_s != sck_hist) && (sck_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    assign active      = armed & ~csn_s;
    assign csn_state   = csn_s;
    assign csn_fall    = armed & csn_hist & ~csn_s;
    assign csn_rise    = armed & ~csn_hist & csn_s;
    assign spi_miso_oe = active;

    assign rx_next   = {rx_shift, mosi_s};
    assign word_done = active & sample_edge & (bit_cnt == CW'(WIDTH - 1));
    assign fetch     = csn_fall | word_done;
    assign pop       = fetch & ~buf_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else if (!active) begin
            bit_cnt <= '0;
        end else if (sample_edge) begin
            rx_shift <= rx_next[WIDTH-2:0];
            bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
        end
    end

    // rx_valid/rx_ready: a word transfers on any cycle where both are high;
    // rx_data is held stable while rx_valid is high and rx_ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= word_done & rx_valid & ~rx_ready;
            if (word_done && (!rx_valid || rx_ready)) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_DEV_SYNC_TX_FIFO_EN
    logic buf_full;

    spi_dev_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (pop),
        .pop_data  (buf_data),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign tx_ready = ~buf_full;
`else
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (tx_valid && tx_ready) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end

    assign tx_ready  = ~hold_full;
    assign buf_empty = ~hold_full;
    assign buf_data  = hold_data;
`endif

    // A shift edge seen with bit_cnt at 0 is the one that must keep the freshly
    // fetched MSB on the wire, in both CPHA settings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift    <= '0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= fetch & buf_empty;
            if (fetch) begin
                tx_shift <= buf_empty ? FILL : buf_data;
            end else if (active && shift_edge && bit_cnt != '0) begin
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign spi_miso = tx_shift[WIDTH-1];

endmodule
